ad_iq_deframer: RTL and testbench

Parametrised receive deframer for AD996x-class converters. It takes a single-lane interleaved I/Q word stream, marked by a frame flag on the first word, and produces a registered, channel-parallel, 16-bit-aligned sample vector. It generalises the fixed one-pair 12-bit I/Q demultiplex of the AD9963 device interface to N complex channels, and adds:
- frame-lock tracking;
- frame-error detection and counting;
- offset-binary conversion;
- selectable output justification.

It sits between the device interface (IDDR/IODELAY capture) and the `axi_*_rx` channel logic, all on `adc_clk`.

---
 rtl/ad_iq_deframer_pkg.sv | 21 ++
 rtl/ad_iq_deframer_fmt.sv | 41 ++++
 rtl/ad_iq_deframer.sv | 124 ++++++++++++
 tb/tb_ad_iq_deframer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_iq_deframer_pkg.sv
// ad_iq_deframer_pkg
//   Shared definitions for the I/Q receive deframer.
//   - Deframer state encoding: HUNT = 0, LOCKED = 1.
//   - Format-select constants. The axi_*_rx register map decodes its format
//     fields against these same values.
package ad_iq_deframer_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Value of cfg_offset_bin
    localparam logic FMT_TWOS_COMP  = 1'b0;
    localparam logic FMT_OFFSET_BIN = 1'b1;

    // Value of cfg_msb_just
    localparam logic FMT_SIGN_EXT   = 1'b0;
    localparam logic FMT_MSB_JUST   = 1'b1;

endpackage

// File: rtl/ad_iq_deframer_fmt.sv
// ad_iq_fmt
//   Combinational per-word format conversion. It runs once on the incoming
//   word, before the word is written into a lane register.
// Ports:
//   data       in  DATA_WIDTH  raw converter word
//   offset_bin in  1           1 = offset binary input (the MSB is inverted)
//   msb_just   in  1           0 = sign-extend, 1 = MSB-justify with zero LSBs
//   fmt        out OUT_WIDTH   formatted lane value
module ad_iq_fmt
    import ad_iq_deframer_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int OUT_WIDTH  = 16
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  offset_bin,
    input  logic                  msb_just,
    output logic [OUT_WIDTH-1:0]  fmt
);

    logic [DATA_WIDTH-1:0] w;
    logic [OUT_WIDTH-1:0]  sext;
    logic [OUT_WIDTH-1:0]  mjust;

    // Inverting the MSB turns offset binary into two's complement.
    assign w = {data[DATA_WIDTH-1] ^ (offset_bin == FMT_OFFSET_BIN), data[DATA_WIDTH-2:0]};

    // When the widths are equal there is no padding, and both formats are the word itself.
    generate
        if (OUT_WIDTH > DATA_WIDTH) begin : g_pad
            assign sext  = {{(OUT_WIDTH-DATA_WIDTH){w[DATA_WIDTH-1]}}, w};
            assign mjust = {w, {(OUT_WIDTH-DATA_WIDTH){1'b0}}};
        end else begin : g_nopad
            assign sext  = w;
            assign mjust = w;
        end
    endgenerate

    assign fmt = (msb_just == FMT_MSB_JUST) ? mjust : sext;

endmodule

// File: rtl/ad_iq_deframer.sv
// ad_iq_deframer
//   Receive deframer for an interleaved I/Q word stream (I0,Q0,I1,Q1,...).
//   It tracks frame lock, formats each word, and collects the words into
//   F = 2*NUM_CHANNELS lane registers. Each completed frame is presented as
//   a registered, channel-parallel vector.
// Ports:
//   adc_clk, adc_rstn             clock, synchronous active-low reset
//   in_valid, in_frame, in_data   word stream; in_frame marks word 0
//   cfg_enable[F]                 lane enables, latched at frame start
//   cfg_offset_bin, cfg_msb_just  per-word format controls
//   clr_err                       clears err_count
//   out_valid, out_enable, out_data   completed frame (lane k at [k*OUT_WIDTH +: OUT_WIDTH])
//   status_locked, status_frame_err, err_count   lock and framing-error status
//
// state  | meaning
// HUNT   | searching for a word that carries in_frame; other words are dropped
// LOCKED | collecting lanes; idx is the lane the next word belongs to
module ad_iq_deframer
    import ad_iq_deframer_pkg::*;
#(
    parameter int NUM_CHANNELS = 1,
    parameter int DATA_WIDTH   = 12,
    parameter int OUT_WIDTH    = 16
) (
    input  logic                                adc_clk,
    input  logic                                adc_rstn,
    input  logic                                in_valid,
    input  logic                                in_frame,
    input  logic [DATA_WIDTH-1:0]               in_data,
    input  logic [2*NUM_CHANNELS-1:0]           cfg_enable,
    input  logic                                cfg_offset_bin,
    input  logic                                cfg_msb_just,
    input  logic                                clr_err,
    output logic                                out_valid,
    output logic [2*NUM_CHANNELS-1:0]           out_enable,
    output logic [2*NUM_CHANNELS*OUT_WIDTH-1:0] out_data,
    output logic                                status_locked,
    output logic                                status_frame_err,
    output logic [15:0]                         err_count
);

    localparam int F = 2 * NUM_CHANNELS;
    localparam int IDX_W = $clog2(F);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(F - 1);

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [OUT_WIDTH-1:0]   lane_q [F];
    logic [F-1:0]           en_q;
    logic [OUT_WIDTH-1:0]   word_fmt;
    logic                   frame_err_c;

    ad_iq_fmt #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_fmt (
        .data       (in_data),
        .offset_bin (cfg_offset_bin),
        .msb_just   (cfg_msb_just),
        .fmt        (word_fmt)
    );

    // While locked, in_frame must be high exactly when idx is 0. A mismatch in
    // either direction is a framing error.
    assign frame_err_c = in_valid && (state == ST_LOCKED) && ((idx == '0) != in_frame);

    assign status_locked = (state == ST_LOCKED);

    always_ff @(posedge adc_clk) begin
        if (!adc_rstn) begin
            state            <= ST_HUNT;
            idx              <= '0;
            en_q             <= '0;
            out_valid        <= 1'b0;
            out_enable       <= '0;
            out_data         <= '0;
            status_frame_err <= 1'b0;
            err_count        <= '0;
            for (int k = 0; k < F; k++) begin
                lane_q[k] <= '0;
            end
        end else begin
            out_valid        <= 1'b0;
            status_frame_err <= frame_err_c;

            if (clr_err) begin
                err_count <= {15'd0, frame_err_c};
            end else if (frame_err_c && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end

            if (in_valid) begin
                if (in_frame) begin
                    // A frame word always starts a new frame. Any partial
                    // frame in progress is abandoned.
                    lane_q[0] <= word_fmt;
                    en_q      <= cfg_enable;
                    idx       <= IDX_W'(1);
                    state     <= ST_LOCKED;
                end else if (state == ST_LOCKED) begin
                    if (idx == '0) begin
                        state <= ST_HUNT;
                    end else begin
                        lane_q[idx] <= word_fmt;
                        if (idx == IDX_LAST) begin
                            // The last word goes straight to the output; it is
                            // not yet visible in lane_q.
                            idx        <= '0;
                            out_valid  <= 1'b1;
                            out_enable <= en_q;
                            for (int k = 0; k < F; k++) begin
                                out_data[k*OUT_WIDTH +: OUT_WIDTH] <=
                                    en_q[k] ? ((k == F - 1) ? word_fmt : lane_q[k]) : '0;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ad_iq_deframer.sv
// tb_ad_iq_deframer
//   Bench for ad_iq_deframer with NUM_CHANNELS=2, DATA_WIDTH=12, OUT_WIDTH=16.
//   It applies a directed vector table, a few hand-written sequences,
//   randomized traffic checked against a frame-level queue model, and
//   error counter saturation.
module tb_ad_iq_deframer;

    localparam int NC = 2;
    localparam int DW = 12;
    localparam int OW = 16;
    localparam int F  = 2 * NC;

    logic              adc_clk = 1'b0;
    logic              adc_rstn = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_frame = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic [F-1:0]      cfg_enable = '1;
    logic              cfg_offset_bin = 1'b0;
    logic              cfg_msb_just = 1'b0;
    logic              clr_err = 1'b0;
    logic              out_valid;
    logic [F-1:0]      out_enable;
    logic [F*OW-1:0]   out_data;
    logic              status_locked;
    logic              status_frame_err;
    logic [15:0]       err_count;

    ad_iq_deframer #(
        .NUM_CHANNELS (NC),
        .DATA_WIDTH   (DW),
        .OUT_WIDTH    (OW)
    ) dut (
        .adc_clk          (adc_clk),
        .adc_rstn         (adc_rstn),
        .in_valid         (in_valid),
        .in_frame         (in_frame),
        .in_data          (in_data),
        .cfg_enable       (cfg_enable),
        .cfg_offset_bin   (cfg_offset_bin),
        .cfg_msb_just     (cfg_msb_just),
        .clr_err          (clr_err),
        .out_valid        (out_valid),
        .out_enable       (out_enable),
        .out_data         (out_data),
        .status_locked    (status_locked),
        .status_frame_err (status_frame_err),
        .err_count        (err_count)
    );

    always #5 adc_clk = ~adc_clk;

    int checks = 0;
    int failures = 0;

    // Frame-level reference model: a queue holds the formatted words of the
    // frame being collected.
    bit              m_locked;
    logic [OW-1:0]   m_q[$];
    logic [F-1:0]    m_en;
    logic            m_ov;
    logic            m_err;
    logic [F*OW-1:0] m_data;
    logic [F-1:0]    m_oen;
    int              m_cnt;

    function automatic logic [OW-1:0] ref_fmt(int d, bit ob, bit mj);
        int w;
        w = d ^ (ob ? (1 << (DW - 1)) : 0);
        if (mj) return OW'(w * (1 << (OW - DW)));
        if (w >= (1 << (DW - 1))) return OW'(w - (1 << DW));
        return OW'(w);
    endfunction

    task automatic model_reset();
        m_locked = 0;
        m_q.delete();
        m_en = '0;
        m_ov = 0;
        m_err = 0;
        m_data = '0;
        m_oen = '0;
        m_cnt = 0;
    endtask

    task automatic model_step();
        bit e;
        logic [OW-1:0] w;
        if (!adc_rstn) begin
            model_reset();
            return;
        end
        e = 0;
        m_ov = 0;
        if (in_valid) begin
            w = ref_fmt(int'(in_data), cfg_offset_bin, cfg_msb_just);
            if (in_frame) begin
                if (m_locked && m_q.size() != 0) e = 1;
                m_q.delete();
                m_q.push_back(w);
                m_en = cfg_enable;
                m_locked = 1;
            end else if (m_locked) begin
                if (m_q.size() == 0) begin
                    e = 1;
                    m_locked = 0;
                end else begin
                    m_q.push_back(w);
                    if (m_q.size() == F) begin
                        m_ov = 1;
                        m_oen = m_en;
                        for (int k = 0; k < F; k++)
                            m_data[k*OW +: OW] = m_en[k] ? m_q[k] : '0;
                        m_q.delete();
                    end
                end
            end
        end
        m_err = e;
        if (clr_err) m_cnt = e ? 1 : 0;
        else if (e && m_cnt < 65535) m_cnt++;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_enable", 64'(out_enable), 64'(m_oen));
        check("status_locked", 64'(status_locked), 64'(m_locked));
        check("status_frame_err", 64'(status_frame_err), 64'(m_err));
        check("err_count", 64'(err_count), 64'(m_cnt));
    endtask

    // One clock: the model consumes the current inputs, and the DUT is sampled #1 after the edge.
    task automatic tick(bit chk);
        model_step();
        @(posedge adc_clk);
        #1;
        if (chk) check_model();
    endtask

    task automatic word(bit v, bit f, logic [DW-1:0] d);
        in_valid = v;
        in_frame = f;
        in_data = d;
        tick(1);
    endtask

    typedef struct {
        bit            v;
        bit            f;
        logic [DW-1:0] d;
        bit            ob;
        bit            mj;
        bit            exp_ov;
        logic [63:0]   exp_data;
        logic [3:0]    exp_oen;
        bit            exp_err;
        bit            exp_lk;
        logic [15:0]   exp_cnt;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    localparam logic [63:0] D1 = 64'hFFFF_0001_07FF_F800;
    localparam logic [63:0] D2 = 64'h0123_7FF0_F800_0000;
    localparam logic [63:0] D3 = 64'h0600_0500_0400_0300;
    localparam logic [63:0] D4 = 64'h000C_000B_000A_FABC;

    initial begin
        int pos;

        vecs[0]  = '{1, 1, 12'h800, 0, 0, 0, 64'h0, 4'h0, 0, 1, 16'd0};
        vecs[1]  = '{1, 0, 12'h7FF, 0, 0, 0, 64'h0, 4'h0, 0, 1, 16'd0};
        vecs[2]  = '{1, 0, 12'h001, 0, 0, 0, 64'h0, 4'h0, 0, 1, 16'd0};
        vecs[3]  = '{1, 0, 12'hFFF, 0, 0, 1, D1,    4'hF, 0, 1, 16'd0};
        vecs[4]  = '{1, 1, 12'h800, 1, 0, 0, D1,    4'hF, 0, 1, 16'd0};
        vecs[5]  = '{1, 0, 12'h000, 1, 0, 0, D1,    4'hF, 0, 1, 16'd0};
        vecs[6]  = '{1, 0, 12'h7FF, 0, 1, 0, D1,    4'hF, 0, 1, 16'd0};
        vecs[7]  = '{1, 0, 12'h123, 0, 0, 1, D2,    4'hF, 0, 1, 16'd0};
        vecs[8]  = '{1, 1, 12'h100, 0, 0, 0, D2,    4'hF, 0, 1, 16'd0};
        vecs[9]  = '{1, 0, 12'h200, 0, 0, 0, D2,    4'hF, 0, 1, 16'd0};
        vecs[10] = '{1, 1, 12'h300, 0, 0, 0, D2,    4'hF, 1, 1, 16'd1};
        vecs[11] = '{1, 0, 12'h400, 0, 0, 0, D2,    4'hF, 0, 1, 16'd1};
        vecs[12] = '{1, 0, 12'h500, 0, 0, 0, D2,    4'hF, 0, 1, 16'd1};
        vecs[13] = '{1, 0, 12'h600, 0, 0, 1, D3,    4'hF, 0, 1, 16'd1};
        vecs[14] = '{1, 0, 12'h700, 0, 0, 0, D3,    4'hF, 1, 0, 16'd2};
        vecs[15] = '{1, 0, 12'h111, 0, 0, 0, D3,    4'hF, 0, 0, 16'd2};
        vecs[16] = '{1, 1, 12'hABC, 0, 0, 0, D3,    4'hF, 0, 1, 16'd2};
        vecs[17] = '{0, 1, 12'h000, 0, 0, 0, D3,    4'hF, 0, 1, 16'd2};
        vecs[18] = '{1, 0, 12'h00A, 0, 0, 0, D3,    4'hF, 0, 1, 16'd2};
        vecs[19] = '{0, 0, 12'hFFF, 0, 0, 0, D3,    4'hF, 0, 1, 16'd2};
        vecs[20] = '{1, 0, 12'h00B, 0, 0, 0, D3,    4'hF, 0, 1, 16'd2};
        vecs[21] = '{1, 0, 12'h00C, 0, 0, 1, D4,    4'hF, 0, 1, 16'd2};

        model_reset();

        // Reset with in_valid toggling: every output stays 0.
        adc_rstn = 1'b0;
        for (int i = 0; i < 4; i++) word(i[0], 1'b1, 12'h5A5);
        adc_rstn = 1'b1;
        word(1'b1, 1'b0, 12'h123);
        word(1'b1, 1'b0, 12'h321);
        check("reset_locked", 64'(status_locked), 64'd0);

        // Directed vector table.
        cfg_enable = 4'hF;
        for (int i = 0; i < NV; i++) begin
            cfg_offset_bin = vecs[i].ob;
            cfg_msb_just = vecs[i].mj;
            word(vecs[i].v, vecs[i].f, vecs[i].d);
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            check($sformatf("vec%0d_out_data", i), 64'(out_data), vecs[i].exp_data);
            check($sformatf("vec%0d_out_enable", i), 64'(out_enable), 64'(vecs[i].exp_oen));
            check($sformatf("vec%0d_frame_err", i), 64'(status_frame_err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_locked", i), 64'(status_locked), 64'(vecs[i].exp_lk));
            check($sformatf("vec%0d_err_count", i), 64'(err_count), 64'(vecs[i].exp_cnt));
        end
        cfg_offset_bin = 0;
        cfg_msb_just = 0;

        // Lane enables are latched at frame start; a change mid-frame waits for the next frame.
        cfg_enable = 4'b0101;
        word(1'b1, 1'b1, 12'h111);
        cfg_enable = 4'b1111;
        word(1'b1, 1'b0, 12'h222);
        word(1'b1, 1'b0, 12'h333);
        word(1'b1, 1'b0, 12'h444);
        check("en_out_enable", 64'(out_enable), 64'h5);
        check("en_out_data", 64'(out_data), 64'h0000_0333_0000_0111);

        // clr_err in the same cycle as an idx=0 error.
        clr_err = 1'b1;
        word(1'b1, 1'b0, 12'h055);
        clr_err = 1'b0;
        check("clr_with_err", 64'(err_count), 64'd1);

        // Reset mid-frame loses the partial frame; afterwards non-frame words are dropped.
        word(1'b1, 1'b1, 12'h010);
        word(1'b1, 1'b0, 12'h020);
        adc_rstn = 1'b0;
        word(1'b1, 1'b0, 12'h030);
        adc_rstn = 1'b1;
        word(1'b1, 1'b0, 12'h040);
        word(1'b1, 1'b0, 12'h050);
        check("midreset_no_out", 64'(out_valid), 64'd0);

        // Randomized traffic: mostly well-formed frames with occasional flipped frame flags.
        pos = 0;
        for (int i = 0; i < 2500; i++) begin
            adc_rstn = ($urandom_range(0, 399) != 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_frame = (pos == 0);
            if ($urandom_range(0, 24) == 0) in_frame = ~in_frame;
            if (in_valid) pos = (pos + 1) % F;
            in_data = DW'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                cfg_enable = F'($urandom);
                cfg_offset_bin = 1'($urandom_range(0, 1));
                cfg_msb_just = 1'($urandom_range(0, 1));
            end
            clr_err = ($urandom_range(0, 49) == 0);
            tick(1);
        end
        adc_rstn = 1'b1;
        clr_err = 1'b0;

        // Saturation: a continuous stream of frame words makes every word after the first an error.
        in_valid = 1'b1;
        in_frame = 1'b1;
        in_data = 12'h0AA;
        for (int i = 0; i < 65540; i++) tick(0);
        check("sat_err_count", 64'(err_count), 64'hFFFF);
        check_model();
        tick(1);
        check("sat_hold", 64'(err_count), 64'hFFFF);

        in_valid = 1'b0;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
